// File: rtl/wr_arb_pkg.sv
// wr_arb_pkg: shared types and defaults for the c1 write-channel arbiter.
package wr_arb_pkg;

    // CCI-P cache-line address/data widths (same layout as the MPF shell types)
    localparam int CL_ADDR_W = 42;
    localparam int CL_DATA_W = 512;

    typedef logic [CL_ADDR_W-1:0] t_cci_clAddr;
    typedef logic [CL_DATA_W-1:0] t_cci_clData;

    localparam int DEFAULT_N_REQ           = 3;
    localparam int DEFAULT_MAX_OUTSTANDING = 64;

    typedef enum logic [1:0] {
        WA_ARB,
        WA_DRAIN,
        WA_DONE
    } e_wr_arb_state;

    // One write line as presented on the c1 channel
    typedef struct packed {
        t_cci_clAddr addr;
        t_cci_clData data;
    } t_wr_req;

    // Width of an index into a request vector of n entries (at least 1 bit)
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wr_channel_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick; first valid index after ptr wins.
module rr_arbiter
    import wr_arb_pkg::*;
#(
    parameter int N  = DEFAULT_N_REQ,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] winner
);

    logic found;
    int   idx;

    // Scan ptr+1 .. ptr+N (mod N); the scan order gives the rotating priority
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
        if (enable && found)
            grant[winner] = 1'b1;
    end

endmodule

// File: rtl/wr_channel_arbiter.sv
// wr_channel_arbiter: shares the CCI-P c1 write channel between N_REQ sources,
// throttles on almost-full / outstanding limit and offers a drain handshake.
// Build macro WR_ARB_STATS_EN adds per-requester grant counters (grant_cnt, stats_clr).
module wr_channel_arbiter
    import wr_arb_pkg::*;
#(
    parameter int N_REQ           = DEFAULT_N_REQ,
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
    parameter int OCNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                clk,
    input  logic                                rst_n,
`ifdef WR_ARB_STATS_EN
    input  logic                                stats_clr,
    output logic [N_REQ-1:0][31:0]              grant_cnt,
`endif
    input  logic [N_REQ-1:0]                    req_valid,
    input  logic [N_REQ-1:0][CL_ADDR_W-1:0]     req_addr,
    input  logic [N_REQ-1:0][CL_DATA_W-1:0]     req_data,
    output logic [N_REQ-1:0]                    req_grant,
    input  logic                                c1_almost_full,
    output logic                                wr_valid,
    output logic [CL_ADDR_W-1:0]                wr_addr,
    output logic [CL_DATA_W-1:0]                wr_data,
    input  logic                                wr_rsp_valid,
    input  logic                                drain_req,
    output logic                                drain_done,
    output logic [OCNT_W-1:0]                   outstanding,
    output logic                                rsp_underflow
);

    localparam int IW = idx_w(N_REQ);

    e_wr_arb_state state, state_nxt;
    logic [IW-1:0] rr_ptr, winner;
    logic [OCNT_W:0] in_flight;
    logic          can_issue, issue;
    t_wr_req       sel;

    // A line sitting in the output register will bump the count next cycle,
    // so it already uses up one slot of the outstanding budget
    assign in_flight = {1'b0, outstanding} + {{OCNT_W{1'b0}}, wr_valid};
    assign can_issue = !c1_almost_full && (state == WA_ARB) && !drain_req &&
                       (in_flight < (OCNT_W+1)'(MAX_OUTSTANDING));

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .enable (can_issue),
        .grant  (req_grant),
        .winner (winner)
    );

    assign issue = |req_grant;
    assign sel   = '{addr: req_addr[winner], data: req_data[winner]};

    // Round-robin pointer remembers the last winner; reset favours requester 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rr_ptr <= IW'(N_REQ - 1);
        else if (issue) rr_ptr <= winner;
    end

    // Output register stage; addr/data only load on a grant and hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_valid <= issue;
            if (issue) begin
                wr_addr <= sel.addr;
                wr_data <= sel.data;
            end
        end
    end

    // Outstanding counter: +1 per issued line, -1 per response; stray responses flag underflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding   <= '0;
            rsp_underflow <= 1'b0;
        end else begin
            case ({wr_valid, wr_rsp_valid})
                2'b10: if (outstanding < OCNT_W'(MAX_OUTSTANDING))
                           outstanding <= outstanding + OCNT_W'(1);
                2'b01: if (outstanding == '0) rsp_underflow <= 1'b1;
                       else                   outstanding   <= outstanding - OCNT_W'(1);
                default: ;
            endcase
        end
    end

    // Drain FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WA_ARB;
        else        state <= state_nxt;
    end

    // Drain FSM next state; DONE waits for both the counter and the output stage to empty
    always_comb begin
        state_nxt  = state;
        drain_done = 1'b0;
        case (state)
            WA_ARB:   if (drain_req) state_nxt = WA_DRAIN;
            WA_DRAIN: begin
                if (!drain_req)                                state_nxt = WA_ARB;
                else if ((outstanding == '0) && !wr_valid)     state_nxt = WA_DONE;
            end
            WA_DONE: begin
                drain_done = 1'b1;
                if (!drain_req) state_nxt = WA_ARB;
            end
            default:  state_nxt = WA_ARB;
        endcase
    end

`ifdef WR_ARB_STATS_EN
    // Per-requester granted-line counters; a clear wins over a same-cycle grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         grant_cnt <= '0;
        else if (stats_clr) grant_cnt <= '0;
        else begin
            for (int i = 0; i < N_REQ; i++)
                if (req_grant[i]) grant_cnt[i] <= grant_cnt[i] + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wr_channel_arbiter.sv
// tb_wr_channel_arbiter: cycle model + scoreboard of issued lines, plus directed scenarios.
module tb_wr_channel_arbiter;
    import wr_arb_pkg::*;

    localparam int N      = 3;
    localparam int MAX    = 6;
    localparam int OCNT_W = $clog2(MAX + 1);

    logic                            clk = 1'b0;
    logic                            rst_n;
    logic [N-1:0]                    req_valid;
    logic [N-1:0][CL_ADDR_W-1:0]     req_addr;
    logic [N-1:0][CL_DATA_W-1:0]     req_data;
    logic [N-1:0]                    req_grant;
    logic                            c1_almost_full;
    logic                            wr_valid;
    logic [CL_ADDR_W-1:0]            wr_addr;
    logic [CL_DATA_W-1:0]            wr_data;
    logic                            wr_rsp_valid;
    logic                            drain_req;
    logic                            drain_done;
    logic [OCNT_W-1:0]               outstanding;
    logic                            rsp_underflow;
`ifdef WR_ARB_STATS_EN
    logic                            stats_clr;
    logic [N-1:0][31:0]              grant_cnt;
`endif

    always #5 clk = ~clk;

    wr_channel_arbiter #(.N_REQ(N), .MAX_OUTSTANDING(MAX)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
`ifdef WR_ARB_STATS_EN
        .stats_clr      (stats_clr),
        .grant_cnt      (grant_cnt),
`endif
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_grant      (req_grant),
        .c1_almost_full (c1_almost_full),
        .wr_valid       (wr_valid),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_rsp_valid   (wr_rsp_valid),
        .drain_req      (drain_req),
        .drain_done     (drain_done),
        .outstanding    (outstanding),
        .rsp_underflow  (rsp_underflow)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model (updated at negedge) ----------------
    int      m_st, m_ptr, m_cnt, m_w, m_idx;
    bit      m_wv, m_uf, m_found;
    logic [N-1:0] eg;
    logic [N-1:0] m_gnt = '0;
    int      wv_seen = 0;
    t_wr_req sbq[$];
    t_wr_req sb_e;
`ifdef WR_ARB_STATS_EN
    int      m_gc[N];
`endif

    always @(negedge clk) begin
        if (!rst_n) begin
            m_st = 0; m_ptr = N - 1; m_cnt = 0; m_wv = 0; m_uf = 0;
            sbq.delete();
`ifdef WR_ARB_STATS_EN
            for (int i = 0; i < N; i++) m_gc[i] = 0;
`endif
        end
        eg = '0; m_found = 0; m_w = 0;
        if (!c1_almost_full && m_st == 0 && !drain_req && (m_cnt + int'(m_wv)) < MAX) begin
            for (int k = 1; k <= N; k++) begin
                m_idx = (m_ptr + k) % N;
                if (!m_found && req_valid[m_idx]) begin m_found = 1; m_w = m_idx; end
            end
            if (m_found) eg[m_w] = 1'b1;
        end
        chk("grant", req_grant, eg);
        chk("wr_valid", wr_valid, m_wv);
        chk("outstanding", outstanding, m_cnt);
        chk("drain_done", drain_done, m_st == 2);
        chk("underflow", rsp_underflow, m_uf);
`ifdef WR_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("grant_cnt", grant_cnt[i], m_gc[i]);
`endif
        if (wr_valid) wv_seen++;
        if (wr_valid && m_wv) begin
            if (sbq.size() == 0) chk("sb_depth", sbq.size(), 1);
            else begin
                sb_e = sbq.pop_front();
                chk("wr_addr", wr_addr, sb_e.addr);
                chk("wr_data", wr_data, sb_e.data);
            end
        end
        m_gnt = rst_n ? eg : '0;
        if (rst_n) begin
            if (m_found) begin
                sbq.push_back('{addr: req_addr[m_w], data: req_data[m_w]});
                m_ptr = m_w;
            end
            case (m_st)
                0: if (drain_req) m_st = 1;
                1: if (!drain_req) m_st = 0; else if (m_cnt == 0 && !m_wv) m_st = 2;
                default: if (!drain_req) m_st = 0;
            endcase
            if (m_wv && !wr_rsp_valid) begin
                if (m_cnt < MAX) m_cnt++;
            end else if (!m_wv && wr_rsp_valid) begin
                if (m_cnt == 0) m_uf = 1; else m_cnt--;
            end
`ifdef WR_ARB_STATS_EN
            if (stats_clr) for (int i = 0; i < N; i++) m_gc[i] = 0;
            else if (m_found) m_gc[m_w]++;
`endif
            m_wv = m_found;
        end
    end

    // ---------------- requesters ----------------
    int left[N];
    int seq = 0;
    bit rsp_auto = 0;

    task automatic new_line(input int i);
        seq++;
        req_addr[i] = (CL_ADDR_W'(i) << 36) | CL_ADDR_W'(seq);
        for (int w = 0; w < 16; w++) req_data[i][w*32 +: 32] = $urandom;
    endtask

    task automatic set_left(input int i, input int n);
        left[i] = n;
        if (n > 0) new_line(i);
        req_valid[i] = (n > 0);
    endtask

    // Advance one clock; granted requesters present their next line
    task automatic cyc();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++)
            if (m_gnt[i] && left[i] > 0) begin
                left[i]--;
                if (left[i] > 0) new_line(i);
            end
        for (int i = 0; i < N; i++) req_valid[i] = (left[i] > 0);
        if (rsp_auto) wr_rsp_valid = (m_cnt != 0);
    endtask

    function automatic bit busy();
        for (int i = 0; i < N; i++) if (left[i] != 0) return 1;
        return (m_cnt != 0) || m_wv;
    endfunction

    task automatic wait_idle();
        rsp_auto = 1;
        for (int n = 0; n < 300 && busy(); n++) cyc();
        rsp_auto = 0;
        wr_rsp_valid = 0;
        @(negedge clk);
        chk("idle_out", outstanding, 0);
        cyc();
    endtask

    logic [N-1:0] t1_exp[6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    initial begin
        rst_n = 0; req_valid = '0; req_addr = '0; req_data = '0;
        c1_almost_full = 0; wr_rsp_valid = 0; drain_req = 0;
        for (int i = 0; i < N; i++) left[i] = 0;
`ifdef WR_ARB_STATS_EN
        stats_clr = 0;
`endif
        @(negedge clk);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_out", outstanding, 0);
        repeat (2) cyc();
        rst_n = 1;

        // all three requesters, responses every cycle -> rotating grants
        rsp_auto = 1;
        for (int i = 0; i < N; i++) set_left(i, 2);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); chk("t1_gnt", req_grant, t1_exp[k]); cyc();
        end
        wait_idle();

        // lone requester, no responses
        set_left(1, 5);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); chk("t2_gnt", req_grant, 3'b010); cyc();
        end
        cyc();
        @(negedge clk); chk("t2_out", outstanding, 5); cyc();
        wait_idle();

        // outstanding limit, then a single response frees exactly one slot
        set_left(0, 20); wv_seen = 0;
        repeat (12) cyc();
        @(negedge clk); chk("t3_writes", wv_seen, MAX); chk("t3_out", outstanding, MAX); cyc();
        wr_rsp_valid = 1; cyc(); wr_rsp_valid = 0;
        repeat (6) cyc();
        @(negedge clk); chk("t3_one_more", wv_seen, MAX + 1); chk("t3_out2", outstanding, MAX); cyc();
        wait_idle();

        // almost-full raised while the granted line sits in the output stage
        rsp_auto = 1;
        set_left(2, 10);
        @(negedge clk); chk("t4_gnt", req_grant, 3'b100); cyc();
        c1_almost_full = 1; wv_seen = 0;
        repeat (5) cyc();
        @(negedge clk); chk("t4_af_writes", wv_seen, 1); cyc();
        c1_almost_full = 0;
        wait_idle();

        // drain with 3 lines outstanding
        set_left(0, 3);
        repeat (5) cyc();
        drain_req = 1; set_left(1, 2);
        @(negedge clk); chk("t5_gnt", req_grant, 0); chk("t5_ndone", drain_done, 0); cyc();
        for (int r = 0; r < 3; r++) begin
            wr_rsp_valid = 1; cyc(); wr_rsp_valid = 0;
        end
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (drain_done) break;
            cyc();
        end
        chk("t5_done", drain_done, 1); cyc();
        drain_req = 0;
        @(negedge clk); chk("t5_done_hold", drain_done, 1); cyc();
        @(negedge clk); chk("t5_done_clr", drain_done, 0); chk("t5_resume", req_grant, 3'b010); cyc();
        wait_idle();

        // stray response, then reset mid-operation and a late response
        wr_rsp_valid = 1; cyc(); wr_rsp_valid = 0;
        @(negedge clk); chk("t6_uf", rsp_underflow, 1); chk("t6_out", outstanding, 0); cyc();
        set_left(0, 3);
        repeat (4) cyc();
        rst_n = 0;
        for (int i = 0; i < N; i++) set_left(i, 0);
        repeat (2) cyc();
        @(negedge clk); chk("t6_rst_uf", rsp_underflow, 0); chk("t6_rst_out", outstanding, 0); cyc();
        rst_n = 1; cyc();
        wr_rsp_valid = 1; cyc(); wr_rsp_valid = 0;
        @(negedge clk); chk("t6_late_uf", rsp_underflow, 1); chk("t6_late_out", outstanding, 0); cyc();

`ifdef WR_ARB_STATS_EN
        set_left(2, 10);
        wait_idle();
        @(negedge clk); chk("st_cnt2", grant_cnt[2], 10); cyc();
        stats_clr = 1; cyc(); stats_clr = 0;
        @(negedge clk); chk("st_clr", grant_cnt[2], 0); cyc();
        stats_clr = 1; set_left(0, 2); cyc(); stats_clr = 0;
        wait_idle();
        @(negedge clk); chk("st_clr_grant", grant_cnt[0], 1); cyc();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
